mem_access: RTL and testbench

- Memory-access stage that consumes the execute stage's result bundle: ALU result used as the address, Rt store data, destination register, and RegWrite/MemRead/MemtoReg/MemWrite controls.
- Drives a request/acknowledge data-memory port with byte lanes, load extraction and sign extension, and a timeout.
- Stalls the pipeline until the access retires, then presents one write-back beat.

---
 rtl/mem_access.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_access.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Pipeline memory-access stage. Turns the execute-stage bundle into
//            a req/ack data-memory transaction with byte lanes, extracts and
//            sign-extends load data, aborts stuck accesses after MAX_WAIT
//            cycles and presents one write-back beat per retired op.
// Options  : MEM_ALIGN_CHECK_EN - adds sticky AddrErr output and rejects
//            misaligned half/word accesses without touching memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
   parameter int MAX_WAIT = 15
) (
   input  logic        Clock,
   input  logic        nReset,
   input  logic        InValid,
   input  logic [31:0] Address,
   input  logic [31:0] StoreData,
   input  logic [4:0]  RAddrIn,
   input  logic        RegWriteIn,
   input  logic        MemReadIn,
   input  logic        MemtoRegIn,
   input  logic        MemWriteIn,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   output logic        Stall,
   output logic        DReq,
   output logic        DWrite,
   output logic [31:0] DAddr,
   output logic [3:0]  DByteEn,
   output logic [31:0] DWData,
   input  logic        DAck,
   input  logic [31:0] DRData,
   output logic [31:0] WBData,
   output logic [4:0]  RAddrOut,
   output logic        RegWriteOut,
   output logic        WBValid,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        AddrErr,
`endif
   output logic        Timeout
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;

   // Attributes of the in-flight access, captured when it is accepted
   logic [31:0]        addr_q;
   logic [1:0]         size_q;
   logic               sgn_q;
   logic [1:0]         lane_q;
   logic [4:0]         rd_q;
   logic               rw_q;
   logic               m2r_q;
   logic               load_q;

   // Registered output copies
   logic               dreq_q;
   logic               dwrite_q;
   logic [31:0]        daddr_q;
   logic [3:0]         dbe_q;
   logic [31:0]        dwdata_q;
   logic [31:0]        wbdata_q;
   logic [4:0]         raddr_q;
   logic               regwr_q;
   logic               wbvalid_q;
   logic               timeout_q;
`ifdef MEM_ALIGN_CHECK_EN
   logic               addrerr_q;
`endif

   logic               w_mem_op;
   logic               w_misalign;
   logic               w_last;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [31:0]        w_load;

   assign w_mem_op = MemReadIn | MemWriteIn;
   // Final permitted ACCESS cycle: no ack here means the access is abandoned
   assign w_last   = (cnt_q == CNT_W'(MAX_WAIT - 1));

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misalign = ((MemSize == 2'b01) && Address[0]) ||
                       (MemSize[1] && (Address[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   // Stall is the only combinational output: hold upstream until retirement
   always_comb begin
      Stall = 1'b0;
      if (state_q == S_ACCESS)
         Stall = !DAck && !w_last;
      else
         Stall = InValid && w_mem_op && !w_misalign;
   end

   // Byte-lane enables and lane-replicated store data for the incoming op
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = StoreData;
      case (MemSize)
         2'b00: begin
            w_be    = 4'b0001 << Address[1:0];
            w_wdata = {4{StoreData[7:0]}};
         end
         2'b01: begin
            w_be    = Address[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{StoreData[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = StoreData;
         end
      endcase
   end

   // Load lane extraction with optional sign extension
   always_comb begin
      w_byte = DRData[7:0];
      case (lane_q)
         2'd0:    w_byte = DRData[7:0];
         2'd1:    w_byte = DRData[15:8];
         2'd2:    w_byte = DRData[23:16];
         default: w_byte = DRData[31:24];
      endcase
      w_half = lane_q[1] ? DRData[31:16] : DRData[15:0];
      case (size_q)
         2'b00:   w_load = {{24{sgn_q & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{sgn_q & w_half[15]}}, w_half};
         default: w_load = DRData;
      endcase
   end

   // Access FSM with all registered outputs
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         sgn_q     <= 1'b0;
         lane_q    <= '0;
         rd_q      <= '0;
         rw_q      <= 1'b0;
         m2r_q     <= 1'b0;
         load_q    <= 1'b0;
         dreq_q    <= 1'b0;
         dwrite_q  <= 1'b0;
         daddr_q   <= '0;
         dbe_q     <= '0;
         dwdata_q  <= '0;
         wbdata_q  <= '0;
         raddr_q   <= '0;
         regwr_q   <= 1'b0;
         wbvalid_q <= 1'b0;
         timeout_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         addrerr_q <= 1'b0;
`endif
      end else begin
         wbvalid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (InValid) begin
                  if (w_mem_op && w_misalign) begin
                     // Rejected misaligned access retires immediately
                     wbvalid_q <= 1'b1;
                     wbdata_q  <= Address;
                     raddr_q   <= RAddrIn;
                     regwr_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                     addrerr_q <= 1'b1;
`endif
                  end else if (w_mem_op) begin
                     state_q  <= S_ACCESS;
                     cnt_q    <= '0;
                     dreq_q   <= 1'b1;
                     dwrite_q <= MemWriteIn & !MemReadIn;
                     daddr_q  <= {Address[31:2], 2'b00};
                     dbe_q    <= w_be;
                     dwdata_q <= w_wdata;
                     addr_q   <= Address;
                     size_q   <= MemSize;
                     sgn_q    <= MemSigned;
                     lane_q   <= Address[1:0];
                     rd_q     <= RAddrIn;
                     rw_q     <= RegWriteIn;
                     m2r_q    <= MemtoRegIn;
                     load_q   <= MemReadIn;
                  end else begin
                     wbvalid_q <= 1'b1;
                     wbdata_q  <= Address;
                     raddr_q   <= RAddrIn;
                     regwr_q   <= RegWriteIn;
                  end
               end
            end
            default: begin
               if (DAck) begin
                  state_q   <= S_IDLE;
                  dreq_q    <= 1'b0;
                  wbvalid_q <= 1'b1;
                  raddr_q   <= rd_q;
                  regwr_q   <= rw_q & load_q;
                  wbdata_q  <= (load_q && m2r_q) ? w_load : addr_q;
               end else if (w_last) begin
                  state_q   <= S_IDLE;
                  dreq_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  wbvalid_q <= 1'b1;
                  raddr_q   <= rd_q;
                  regwr_q   <= 1'b0;
                  wbdata_q  <= addr_q;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign DReq        = dreq_q;
   assign DWrite      = dwrite_q;
   assign DAddr       = daddr_q;
   assign DByteEn     = dbe_q;
   assign DWData      = dwdata_q;
   assign WBData      = wbdata_q;
   assign RAddrOut    = raddr_q;
   assign RegWriteOut = regwr_q;
   assign WBValid     = wbvalid_q;
   assign Timeout     = timeout_q;
`ifdef MEM_ALIGN_CHECK_EN
   assign AddrErr     = addrerr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access: directed scenarios followed
//            by randomized ops compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

   localparam int MAX_WAIT = 15;

   logic        Clock, nReset, InValid;
   logic [31:0] Address, StoreData;
   logic [4:0]  RAddrIn;
   logic        RegWriteIn, MemReadIn, MemtoRegIn, MemWriteIn;
   logic [1:0]  MemSize;
   logic        MemSigned;
   logic        Stall, DReq, DWrite;
   logic [31:0] DAddr;
   logic [3:0]  DByteEn;
   logic [31:0] DWData;
   logic        DAck;
   logic [31:0] DRData, WBData;
   logic [4:0]  RAddrOut;
   logic        RegWriteOut, WBValid, Timeout;
`ifdef MEM_ALIGN_CHECK_EN
   logic        AddrErr;
`endif

   int errors = 0;
   int checks = 0;
   bit tflag  = 0;   // expected sticky Timeout

   mem_access #(.MAX_WAIT(MAX_WAIT)) dut (
      .Clock(Clock), .nReset(nReset), .InValid(InValid),
      .Address(Address), .StoreData(StoreData), .RAddrIn(RAddrIn),
      .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemtoRegIn(MemtoRegIn),
      .MemWriteIn(MemWriteIn), .MemSize(MemSize), .MemSigned(MemSigned),
      .Stall(Stall), .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr),
      .DByteEn(DByteEn), .DWData(DWData), .DAck(DAck), .DRData(DRData),
      .WBData(WBData), .RAddrOut(RAddrOut), .RegWriteOut(RegWriteOut),
      .WBValid(WBValid),
`ifdef MEM_ALIGN_CHECK_EN
      .AddrErr(AddrErr),
`endif
      .Timeout(Timeout)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model (plain arithmetic) ----------------
   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 0) return 4'(1 << (a % 4));
      if (sz == 1) return 4'(3 << (2 * ((a / 2) % 2)));
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 0) return (d % 256) * 32'h0101_0101;
      if (sz == 1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic sg,
                                        input logic [31:0] a, input logic [31:0] r);
      logic [31:0] v;
      if (sz >= 2) return r;
      if (sz == 0) begin
         v = (r >> ((a % 4) * 8)) % 256;
         if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      end else begin
         v = (r >> (((a / 2) % 2) * 16)) % 65536;
         if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic scramble();
      Address    = $urandom;
      StoreData  = $urandom;
      RAddrIn    = 5'($urandom);
      RegWriteIn = 1'($urandom);
      MemReadIn  = 1'($urandom);
      MemWriteIn = 1'($urandom);
      MemtoRegIn = 1'($urandom);
      MemSize    = 2'($urandom);
      MemSigned  = 1'($urandom);
   endtask

   task automatic idle();
      InValid = 1'b0;
      DAck    = 1'($urandom);
      DRData  = $urandom;
      @(posedge Clock); #1;
      DAck = 1'b0;
      chk("idle_wbvalid", WBValid, 0);
      chk("idle_dreq", DReq, 0);
   endtask

   task automatic nonmem(input logic [31:0] a, input logic [4:0] ra, input logic rw);
      scramble();
      InValid = 1'b1; Address = a; RAddrIn = ra; RegWriteIn = rw;
      MemReadIn = 1'b0; MemWriteIn = 1'b0;
      DAck = 1'($urandom);
      @(negedge Clock);
      chk("nm_stall", Stall, 0);
      @(posedge Clock); #1;
      DAck = 1'b0;
      chk("nm_wbvalid", WBValid, 1);
      chk("nm_wbdata", WBData, a);
      chk("nm_raddr", RAddrOut, ra);
      chk("nm_regwr", RegWriteOut, rw);
      chk("nm_dreq", DReq, 0);
   endtask

   task automatic mem_op(input logic [31:0] a, input logic [31:0] sd, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [4:0] ra, input logic rw, input logic m2r,
                         input int waits, input logic [31:0] rdat);
      bit tmo;
      InValid = 1'b1; Address = a; StoreData = sd; MemReadIn = rd; MemWriteIn = wr;
      MemSize = sz; MemSigned = sg; RAddrIn = ra; RegWriteIn = rw; MemtoRegIn = m2r;
      DAck = 1'($urandom);
      @(negedge Clock);
      chk("mo_stall_idle", Stall, 1);
      @(posedge Clock); #1;
      InValid = 1'b0;
      scramble();
      chk("mo_dreq", DReq, 1);
      chk("mo_dwrite", DWrite, wr & !rd);
      chk("mo_daddr", DAddr, a - (a % 4));
      chk("mo_dbyteen", DByteEn, m_be(sz, a));
      chk("mo_dwdata", DWData, m_wd(sz, sd));
      chk("mo_wbvalid_busy", WBValid, 0);
      for (int c = 0; c < MAX_WAIT; c++) begin
         DAck   = (c == waits);
         DRData = (c == waits) ? rdat : $urandom;
         @(negedge Clock);
         chk("mo_stall_acc", Stall, (c == waits || c == MAX_WAIT - 1) ? 0 : 1);
         chk("mo_dreq_hold", DReq, 1);
         @(posedge Clock); #1;
         if (c == waits || c == MAX_WAIT - 1) break;
      end
      DAck = 1'b0;
      tmo = (waits > MAX_WAIT - 1);
      if (tmo) tflag = 1'b1;
      chk("mo_dreq_done", DReq, 0);
      chk("mo_wbvalid", WBValid, 1);
      chk("mo_raddr", RAddrOut, ra);
      chk("mo_regwr", RegWriteOut, rw & rd & !tmo);
      chk("mo_timeout", Timeout, tflag);
      if (rd && !tmo)
         chk("mo_wbdata", WBData, m2r ? m_ld(sz, sg, a, rdat) : a);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, Stall, 0);
      chk({tag, "_dreq"}, DReq, 0);
      chk({tag, "_dwrite"}, DWrite, 0);
      chk({tag, "_daddr"}, DAddr, 0);
      chk({tag, "_dbyteen"}, DByteEn, 0);
      chk({tag, "_dwdata"}, DWData, 0);
      chk({tag, "_wbdata"}, WBData, 0);
      chk({tag, "_raddr"}, RAddrOut, 0);
      chk({tag, "_regwr"}, RegWriteOut, 0);
      chk({tag, "_wbvalid"}, WBValid, 0);
      chk({tag, "_timeout"}, Timeout, 0);
`ifdef MEM_ALIGN_CHECK_EN
      chk({tag, "_addrerr"}, AddrErr, 0);
`endif
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin
      logic [31:0] a;
      logic        rd, wr;
      logic [1:0]  sz;
      int          w;

      nReset = 1'b0; InValid = 1'b0; DAck = 1'b0; DRData = '0;
      scramble();
      InValid = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk_all_zero("reset");
      @(negedge Clock); nReset = 1'b1;
      @(posedge Clock); #1;

      // Non-memory op
      nonmem(32'h0000_1234, 5'd5, 1'b1);
      idle();

      // Signed byte load from lane 3 after two wait cycles
      mem_op(32'h0000_0103, $urandom, 1, 0, 2'b00, 1, 5'd7, 1, 1, 2, 32'h8000_0000);
      chk("sbyte_wbdata", WBData, 32'hFFFF_FF80);
      idle();

      // Half store in upper lanes
      InValid = 1'b1; Address = 32'h0000_0202; StoreData = 32'hDEAD_BEEF;
      MemReadIn = 0; MemWriteIn = 1; MemSize = 2'b01; MemSigned = 0;
      RAddrIn = 5'd3; RegWriteIn = 1; MemtoRegIn = 0;
      @(posedge Clock); #1;
      InValid = 1'b0;
      chk("hst_dbyteen", DByteEn, 4'b1100);
      chk("hst_dwdata", DWData, 32'hBEEF_BEEF);
      chk("hst_dwrite", DWrite, 1);
      DAck = 1'b1;
      @(posedge Clock); #1;
      DAck = 1'b0;
      chk("hst_wbvalid", WBValid, 1);
      chk("hst_regwr", RegWriteOut, 0);
      idle();

      // Timeout on a word load, then normal ops with Timeout held
      mem_op(32'h0000_0040, $urandom, 1, 0, 2'b10, 0, 5'd9, 1, 1, 40, $urandom);
      nonmem(32'h0000_0055, 5'd2, 1'b1);
      chk("tmo_sticky_nm", Timeout, 1);
      mem_op(32'h0000_0081, $urandom, 1, 0, 2'b00, 0, 5'd4, 1, 1, 0, 32'h0000_AB00);

      // Reset asserted mid-access
      InValid = 1'b1; Address = 32'h0000_0300; MemReadIn = 1; MemWriteIn = 0;
      MemSize = 2'b10; RAddrIn = 5'd1; RegWriteIn = 1; MemtoRegIn = 1;
      @(posedge Clock); #1;
      InValid = 1'b0;
      chk("rst_pre_dreq", DReq, 1);
      repeat (2) @(posedge Clock);
      @(negedge Clock); #2;
      nReset = 1'b0;
      #1;
      chk("rst_async_dreq", DReq, 0);
      @(posedge Clock);
      @(negedge Clock); nReset = 1'b1;
      #1;
      tflag = 1'b0;
      chk_all_zero("rst_mid");
      DAck = 1'b1; DRData = $urandom;
      @(posedge Clock); #1;
      DAck = 1'b0;
      chk("late_ack_wbvalid", WBValid, 0);
      chk("late_ack_dreq", DReq, 0);

      // Ack on the very last allowed cycle wins over timeout
      mem_op(32'h0000_0402, $urandom, 1, 0, 2'b01, 1, 5'd6, 1, 1, MAX_WAIT - 1, 32'h1234_9ABC);

      // Read and write both set: read wins
      mem_op(32'h0000_0500, $urandom, 1, 1, 2'b10, 0, 5'd8, 1, 1, 1, $urandom);

      // Randomized ops, some back-to-back
      for (int i = 0; i < 40; i++) begin
         a  = $urandom;
         sz = 2'($urandom);
`ifdef MEM_ALIGN_CHECK_EN
         if (sz == 2'b01) a[0] = 1'b0;
         if (sz[1]) a[1:0] = 2'b00;
`endif
         if ($urandom_range(0, 3) == 0) begin
            nonmem(a, 5'($urandom), 1'($urandom));
         end else begin
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            w  = ($urandom_range(0, 9) == 0) ? MAX_WAIT + 2 : $urandom_range(0, 4);
            mem_op(a, $urandom, rd, wr, sz, 1'($urandom), 5'($urandom), 1'($urandom),
                   1'($urandom), w, $urandom);
         end
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();

`ifdef MEM_ALIGN_CHECK_EN
      // Misaligned word load is rejected without a memory request
      InValid = 1'b1; Address = 32'h0000_0006; MemReadIn = 1; MemWriteIn = 0;
      MemSize = 2'b10; RAddrIn = 5'd11; RegWriteIn = 1; MemtoRegIn = 1;
      @(posedge Clock); #1;
      InValid = 1'b0;
      chk("al_dreq", DReq, 0);
      chk("al_addrerr", AddrErr, 1);
      chk("al_wbvalid", WBValid, 1);
      chk("al_regwr", RegWriteOut, 0);
      idle();
      chk("al_sticky", AddrErr, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
